sr_shift_reg: RTL
=================

SR_SHIFT_REG -- requirements
Module: sr_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RST_VAL, default all-zero (WIDTH bits), giving the value q takes at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: update enable; low means hold.
REQ-006 The block SHALL have port mode, input, 2 bits: operation select.
REQ-007 The block SHALL have port s, input, WIDTH bits: per-bit set request (SR mode).
REQ-008 The block SHALL have port r, input, WIDTH bits: per-bit reset request (SR mode).
REQ-009 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port sin, input, 1 bit: serial input for shift mode.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-012 The block SHALL have port qi, output, WIDTH bits: registered complement of q.
REQ-013 The block SHALL have port sout, output, 1 bit: registered bit shifted out of the MSB.
REQ-014 The block SHALL have port changed, output, 1 bit: one-cycle pulse, high when q changed on the previous edge.

Function
REQ-015 The block SHALL hold q unchanged, regardless of mode, on any clk edge where en=0.
REQ-016 The block SHALL hold q on mode 2'b00 (HOLD).
REQ-017 The block SHALL, on mode 2'b01 (SR), update each bit independently: s=1,r=0 -> 1; s=0,r=1 -> 0; s=0,r=0 -> hold; s=1,r=1 -> per REQ-027/028.
REQ-018 The block SHALL, on mode 2'b10 (SHIFT), load q <= {q[WIDTH-2:0], sin} and sout <= old q[WIDTH-1].
REQ-019 The block SHALL, on mode 2'b11 (LOAD), load q <= d.
REQ-020 The block SHALL update sout only in SHIFT mode with en=1, holding it otherwise.
REQ-021 The block SHALL keep qi == ~q on every cycle, with both updated on the same edge (zero relative latency).
REQ-022 The block SHALL drive changed=1 in the cycle after any edge where the new q differs from the old q, and 0 otherwise, including for LOAD of an identical value.
REQ-023 The block SHALL make all updates visible one cycle after the sampling edge, with no combinational input-to-output path.

Reset
REQ-024 The block SHALL, while rst=1, immediately force q=RST_VAL, qi=~RST_VAL, sout=0, changed=0, independent of clk.
REQ-025 The block SHALL take its first functional update on the first rising clk edge after rst deasserts; an operation in flight when rst asserts is discarded.
REQ-026 The block SHALL NOT pulse changed due to reset entry or exit.

Configuration
REQ-027 The block SHALL, with macro SR_SHIFT_REG_TOGGLE_EN defined, toggle a bit on s=1,r=1 in SR mode (JK behaviour).
REQ-028 The block SHALL, without SR_SHIFT_REG_TOGGLE_EN, resolve s=1,r=1 as reset-dominant (bit <= 0).

Structure
REQ-029 The block SHALL take mode encodings MODE_HOLD, MODE_SR, MODE_SHIFT and MODE_LOAD from shared package sr_shift_reg_pkg.
REQ-030 The block SHALL compute the per-bit SR next-state in one sub-module, sr_bit_cell (inputs q, s, r; output next), instantiated WIDTH times via generate.
REQ-031 The block SHALL keep all state flops in sr_shift_reg; sr_bit_cell SHALL be purely combinational.

Verification (WIDTH=8, RST_VAL=8'h00)
REQ-032 The bench SHALL cover: rst pulse mid-cycle -> q=8'h00, qi=8'hFF, sout=0, changed=0 immediately, without waiting for clk.
REQ-033 The bench SHALL cover: LOAD d=8'hA5 -> q=8'hA5, qi=8'h5A, changed=1 next cycle; a repeat LOAD of 8'hA5 -> changed=0.
REQ-034 The bench SHALL cover: q=8'h81, SHIFT with sin=1 over two edges -> q=8'h03 then 8'h07, and sout=1 then 0.
REQ-035 The bench SHALL cover: q=8'h0F, SR mode with s=8'hF0, r=8'h0F -> q=8'hF0.
REQ-036 The bench SHALL cover: q=8'h0F, s=r=8'hFF -> q=8'hF0 with SR_SHIFT_REG_TOGGLE_EN, and q=8'h00 without it.
REQ-037 The bench SHALL cover: en=0 with mode=LOAD and d=8'h3C -> q unchanged, changed=0, sout unchanged.

Source files
------------

// File: rtl/sr_shift_reg_pkg.sv
// Shared definitions for the SR / shift / load register.
// Configuration macro: SR_SHIFT_REG_TOGGLE_EN. When it is defined, s=1,r=1 in
// SR mode toggles the bit (JK behaviour). When it is not defined, reset wins.
package sr_shift_reg_pkg;

    // Operation select encodings for the mode port.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SR    = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    // Legal register width range.
    localparam int unsigned SR_WIDTH_MIN = 2;
    localparam int unsigned SR_WIDTH_MAX = 64;

    // Next state of a single SR bit. The s=1,r=1 case is the only
    // configuration-dependent behaviour in the block.
    function automatic logic sr_resolve(input logic q, input logic s, input logic r);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
`ifdef SR_SHIFT_REG_TOGGLE_EN
                nxt = ~q;
`else
                nxt = 1'b0;
`endif
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// Per-bit SR next-state cell; purely combinational, holds no state.
// s=1,r=1 handling depends on SR_SHIFT_REG_TOGGLE_EN (see the package).
module sr_bit_cell
    import sr_shift_reg_pkg::*;
(
    input  logic q,
    input  logic s,
    input  logic r,
    output logic next
);

    // Resolve the set/reset request against the current bit value.
    always_comb begin
        next = sr_resolve(q, s, r);
    end

endmodule

// File: rtl/sr_shift_reg.sv
// Multi-mode register: hold, per-bit SR, serial shift-left, parallel load.
// Outputs q, qi (complement), sout and the changed pulse are all registered;
// reset is asynchronous and active-high.
// Configuration macro: SR_SHIFT_REG_TOGGLE_EN selects JK-style toggle for
// s=1,r=1 in SR mode; the default build resolves that case reset-dominant.
module sr_shift_reg
    import sr_shift_reg_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qi,
    output logic             sout,
    output logic             changed
);

    if (WIDTH < SR_WIDTH_MIN || WIDTH > SR_WIDTH_MAX) begin : g_width_check
        $error("sr_shift_reg: WIDTH out of range");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qi_q;
    logic             sout_q;
    logic             sout_d;
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] sr_next;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // One combinational SR cell per bit, all fed from the registered state.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_bit_cell u_cell (
            .q    (q_q[i]),
            .s    (s[i]),
            .r    (r[i]),
            .next (sr_next[i])
        );
    end

    // Next-state selection: en low or HOLD keeps everything; sout moves only on SHIFT.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en) begin
            case (mode_sel)
                MODE_SR: begin
                    q_d = sr_next;
                end
                MODE_SHIFT: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    q_d = d;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
        // Pulse only on a real value change, so reloading the same value is silent.
        changed_d = (q_d != q_q);
    end

    // State registers; qi is registered from the same next state so it never lags q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RST_VAL;
            qi_q      <= ~RST_VAL;
            sout_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qi_q      <= ~q_d;
            sout_q    <= sout_d;
            changed_q <= changed_d;
        end
    end

    assign q       = q_q;
    assign qi      = qi_q;
    assign sout    = sout_q;
    assign changed = changed_q;

endmodule
